ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Owns the PC register and drives a req/ack instruction-memory handshake.
- Presents one fetched instruction at a time to the IF/ID register.
- Consumes the ID-stage branch decision (comparator result plus NPC op) to redirect fetch, with MIPS delay-slot semantics: the instruction after a branch is always delivered.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_LIMIT, 32'h0000_6FFF, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: IF/ID holds; no hand-off this cycle.
- id_valid  in  1  ID stage holds a real instruction.
- id_pc  in  32  PC of the instruction in ID.
- npc_op  in  2  00 SEQ, 01 BRANCH, 10 JUMP (j/jal), 11 JREG (jr/jalr).
- br_take  in  1  branch comparator result for the ID instruction.
- imm16  in  16  branch offset.
- instr_index  in  26  jump field.
- jr_target  in  32  forwarded rs value.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ack  in  1  one-cycle response strobe.
- imem_rdata  in  32  instruction; valid when imem_ack=1.
- if_valid  out  1  if_pc/if_instr hold a fetched instruction.
- if_pc  out  32  PC of the presented instruction.
- if_instr  out  32  presented instruction.
- if_adel  out  1  presented slot is an address-error fetch.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=RESET_PC, pend_valid=0, pend_target=0.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, if_adel=0.
- FSM states: IDLE, REQ, HOLD.
  - IDLE -> REQ unconditionally. The first request is issued in the 2nd cycle after reset release.
  - REQ, pc legal: imem_req=1, imem_addr=pc. On imem_ack, capture if_instr=imem_rdata, if_pc=pc, if_adel=0, and go to HOLD.
  - REQ, pc illegal (pc[1:0]!=0, pc<IMEM_BASE, or pc>IMEM_LIMIT): no request. Next cycle go to HOLD with if_instr=0, if_pc=pc, if_adel=1.
  - HOLD: if_valid=1, imem_req=0. If stall=1, stay with all outputs frozen. If stall=0 (hand-off): pc<=next_pc, go to REQ, if_valid=0 next cycle.
- Timing: minimum 2 cycles per instruction (ack cycle plus hand-off cycle). Ack latency is unbounded; imem_req stays high with a stable address until ack.
- Redirect event: id_valid && !stall && (npc_op==JUMP || npc_op==JREG || (npc_op==BRANCH && br_take)).
- Redirect targets (all 32-bit, wrap mod 2^32):
  - BRANCH: id_pc + 4 + (sext(imm16) << 2).
  - JUMP: {id_pc_plus4[31:28], instr_index, 2'b00}, where id_pc_plus4 = id_pc + 4.
  - JREG: jr_target, unmodified; misalignment is caught as illegal pc.
- next_pc at hand-off:
  - Redirect event in the same cycle: its target. This is the delay-slot hand-off, so pending is bypassed.
  - Else if pend_valid: pend_target, and clear pend_valid.
  - Else: pc + 4.
- Redirect event outside a hand-off cycle: pend_valid<=1, pend_target<=target. The in-flight or held instruction is the delay slot and is always delivered; it is never discarded.
- A second redirect while pend_valid=1 overwrites the pending target. This cannot occur legally; the bench checks it via assertion only.
- stall=1 suppresses redirect capture, because ID is held and the event re-evaluates next cycle.
- Asserting reset_n low mid-request drops imem_req immediately. The memory side must ignore a late ack.
- imem_ack while not in REQ is ignored.

Decomposition:
- Shared package (mips_defs):
  - NPC_SEQ/NPC_BRANCH/NPC_JUMP/NPC_JREG 2-bit constants.
  - IF_IDLE/IF_REQ/IF_HOLD state encodings.
  - Default reset PC and IMEM bounds.
- One sub-module: npc_calc, purely combinational. Inputs id_pc, npc_op, br_take, imm16, instr_index, jr_target. Outputs redirect_taken, redirect_target.
- FSM, PC, pending and output registers live in ifu_fetch.

Test Plan:
- Reset release, ack 1 cycle after each req, stall=0 -> imem_addr sequence 0x3000, 0x3004, 0x3008. if_valid pulses every 2nd cycle with matching if_pc.
- id_pc=0x3000, npc_op=BRANCH, br_take=1, imm16=0xFFFF, no stall -> delivered order 0x3004 (delay slot), then 0x3000. Same with br_take=0 -> 0x3004, 0x3008.
- JUMP at id_pc=0x3010, instr_index=0x0000C10 -> delay slot 0x3014 delivered, then fetch 0x3040. Repeat with redirect arriving while the delay-slot req waits 3 cycles for ack -> pend_valid set, then 0x3040 fetched.
- HOLD with stall=1 for 4 cycles -> if_valid/if_pc/if_instr stable, imem_req=0, pc unchanged. Release -> next fetch is pc+4.
- JREG with jr_target=0x3002, then separately 0x8000 -> no imem_req for that pc. if_valid=1, if_adel=1, if_instr=0, if_pc=0x3002 / 0x8000.
- reset_n low while imem_req=1 at pc=0x3008, ack arrives the next cycle -> imem_req=0 and if_valid=0 immediately. Ack ignored. After release, first fetch is 0x3000.

Source files
------------

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared NPC opcodes, fetch FSM states and IMEM bounds
// Purpose: constants and a legality helper shared by the fetch stage and its
// next-PC calculator. No ports.
package mips_defs;

    // Next-PC operation driven by the ID stage.
    localparam logic [1:0] NPC_SEQ    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JREG   = 2'b11;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_IMEM_BASE  = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_IMEM_LIMIT = 32'h0000_6FFF;

    // A fetch address is legal when word aligned and inside [base, limit].
    function automatic logic fetch_addr_legal(input logic [31:0] addr,
                                              input logic [31:0] base,
                                              input logic [31:0] limit);
        return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction-memory req/ack handshake bundle
// Purpose: groups the fetch request and response signals.
//   imem_req   fetch request, held until imem_ack
//   imem_addr  fetch address, stable while imem_req=1
//   imem_ack   one-cycle response strobe
//   imem_rdata instruction word, valid with imem_ack
// master = fetch unit, slave = instruction memory.
interface ifu_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational redirect decision and target for the ID instruction
// Purpose: turns the ID-stage NPC op and branch result into a redirect flag
// and a 32-bit target (all arithmetic wraps mod 2^32).
//   id_pc, npc_op, br_take, imm16, instr_index, jr_target  in
//   redirect_taken  out  ID instruction changes control flow
//   redirect_target out  where fetch continues after the delay slot
module npc_calc
    import mips_defs::*;
(
    input  logic [31:0] id_pc,
    input  logic [1:0]  npc_op,
    input  logic        br_take,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic        redirect_taken,
    output logic [31:0] redirect_target
);

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;

    always_comb begin
        pc_plus4        = id_pc + 32'd4;
        br_offset       = {{14{imm16[15]}}, imm16, 2'b00};
        redirect_taken  = 1'b0;
        redirect_target = pc_plus4;
        case (npc_op)
            NPC_SEQ: begin
                redirect_taken  = 1'b0;
            end
            NPC_BRANCH: begin
                redirect_taken  = br_take;
                redirect_target = pc_plus4 + br_offset;
            end
            NPC_JUMP: begin
                redirect_taken  = 1'b1;
                redirect_target = {pc_plus4[31:28], instr_index, 2'b00};
            end
            NPC_JREG: begin
                // Misaligned rs values pass through; the fetch FSM flags them.
                redirect_taken  = 1'b1;
                redirect_target = jr_target;
            end
            default: begin
                redirect_taken  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage with delay-slot redirect
// Purpose: owns the PC, fetches one instruction at a time over the imem
// handshake and presents it to IF/ID; ID-stage redirects take effect after
// the delay slot.
//   clk, reset_n                 clock, async active-low reset
//   stall                        IF/ID holds, no hand-off
//   id_valid/id_pc/npc_op/...    ID-stage branch decision inputs
//   imem (ifu_fetch_if.master)   instruction memory req/ack
//   if_valid/if_pc/if_instr/if_adel  presented slot
module ifu_fetch
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] IMEM_BASE  = DEFAULT_IMEM_BASE,
    parameter logic [31:0] IMEM_LIMIT = DEFAULT_IMEM_LIMIT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               id_valid,
    input  logic [31:0]        id_pc,
    input  logic [1:0]         npc_op,
    input  logic               br_take,
    input  logic [15:0]        imm16,
    input  logic [25:0]        instr_index,
    input  logic [31:0]        jr_target,
    ifu_fetch_if.master        imem,
    output logic               if_valid,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_instr,
    output logic               if_adel
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        imem_req_q, imem_req_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_adel_q, if_adel_d;

    logic        redirect_taken;
    logic [31:0] redirect_target;
    logic        redirect_evt;
    logic        handoff;
    logic        pc_legal;

    npc_calc u_npc_calc (
        .id_pc           (id_pc),
        .npc_op          (npc_op),
        .br_take         (br_take),
        .imm16           (imm16),
        .instr_index     (instr_index),
        .jr_target       (jr_target),
        .redirect_taken  (redirect_taken),
        .redirect_target (redirect_target)
    );

    // A stalled ID re-presents its decision next cycle, so ignore it now.
    assign redirect_evt = id_valid && !stall && redirect_taken;
    assign handoff      = (state_q == IF_HOLD) && !stall;
    assign pc_legal     = fetch_addr_legal(pc_q, IMEM_BASE, IMEM_LIMIT);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_adel_d     = if_adel_q;

        case (state_q)
            IF_IDLE: begin
                state_d = IF_REQ;
            end
            IF_REQ: begin
                if (!pc_legal) begin
                    // Address error: present an empty slot without touching memory.
                    state_d    = IF_HOLD;
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = 32'd0;
                    if_adel_d  = 1'b1;
                end else if (imem.imem_ack) begin
                    state_d    = IF_HOLD;
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = imem.imem_rdata;
                    if_adel_d  = 1'b0;
                end
            end
            IF_HOLD: begin
                if (!stall) begin
                    state_d    = IF_REQ;
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IF_IDLE;
            end
        endcase

        if (handoff) begin
            // A redirect in the hand-off cycle means the slot leaving now is
            // its delay slot, so its target wins over anything pending.
            if (redirect_evt) begin
                pc_d = redirect_target;
            end else if (pend_valid_q) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = pc_q + 32'd4;
            end
            pend_valid_d = 1'b0;
        end else if (redirect_evt) begin
            // The in-flight or held slot is the delay slot; remember the target.
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
        end

        imem_req_d = (state_d == IF_REQ) && fetch_addr_legal(pc_d, IMEM_BASE, IMEM_LIMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IF_IDLE;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            imem_req_q    <= 1'b0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= 32'd0;
            if_instr_q    <= 32'd0;
            if_adel_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            imem_req_q    <= imem_req_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_adel_q     <= if_adel_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = if_instr_q;
    assign if_adel        = if_adel_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_pc = 32'd0;
    logic [1:0]  npc_op = 2'd0;
    logic        br_take = 1'b0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] instr_index = 26'd0;
    logic [31:0] jr_target = 32'd0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_adel;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mem_lat = 0;
    bit mem_rand = 1'b0;
    bit force_ack = 1'b0;

    ifu_fetch_if imem ();

    ifu_fetch dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .npc_op      (npc_op),
        .br_take     (br_take),
        .imm16       (imm16),
        .instr_index (instr_index),
        .jr_target   (jr_target),
        .imem        (imem),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_adel     (if_adel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    function automatic bit model_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFF);
    endfunction

    function automatic logic [31:0] model_target(input logic [1:0] op, input logic [31:0] ipc,
                                                 input logic [15:0] imm, input logic [25:0] idx,
                                                 input logic [31:0] jr);
        int          off;
        logic [31:0] nxt;
        nxt = ipc + 32'd4;
        off = int'($signed(imm)) * 4;
        if (op == 2'd1) return nxt + 32'(off);
        if (op == 2'd2) return (nxt & 32'hF000_0000) | (32'(idx) * 32'd4);
        return jr;
    endfunction

    // Instruction memory: random or fixed latency, checks address legality and stability.
    initial begin : memory
        int          cnt;
        int          lat;
        logic [31:0] held;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'd0;
        cnt = 0; lat = 0; held = 32'd0;
        forever begin
            @(negedge clk);
            if (force_ack) begin
                imem.imem_ack   = 1'b1;
                imem.imem_rdata = 32'hBAD0_BAD0;
                cnt = 0;
            end else if (!reset_n || !imem.imem_req) begin
                imem.imem_ack = 1'b0;
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    held = imem.imem_addr;
                    lat  = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
                    checks++;
                    if (!model_legal(held)) begin
                        errors++;
                        $display("FAIL req_legal addr=%h requested, required no request", held);
                    end
                end else begin
                    checks++;
                    if (imem.imem_addr !== held) begin
                        errors++;
                        $display("FAIL addr_stable got=%h want=%h", imem.imem_addr, held);
                    end
                end
                if (cnt >= lat) begin
                    imem.imem_ack   = 1'b1;
                    imem.imem_rdata = mem_fn(held);
                    cnt = 0;
                end else begin
                    imem.imem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; stall = 1'b0; id_valid = 1'b0; mem_rand = 1'b0; mem_lat = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Waits for the next handed-off slot; returns at the negedge after hand-off.
    task automatic wait_slot(output logic [31:0] pc, output logic [31:0] ins,
                             output logic adel, output bit ok);
        ok = 1'b0; pc = 32'd0; ins = 32'd0; adel = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (if_valid && !stall) begin
                pc = if_pc; ins = if_instr; adel = if_adel; ok = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic issue_id(input logic [1:0] op, input logic [31:0] ipc, input logic take,
                            input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
        id_valid = 1'b1; npc_op = op; id_pc = ipc; br_take = take;
        imm16 = imm; instr_index = idx; jr_target = jr;
        @(negedge clk);
        id_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b want=0", imem.imem_req); end
        checks++; if (imem.imem_addr !== 32'h3000) begin errors++; $display("FAIL rst_addr got=%h want=00003000", imem.imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid got=%b want=0", if_valid); end
        checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL rst_if_pc got=%h want=0", if_pc); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL rst_if_instr got=%h want=0", if_instr); end
        checks++; if (if_adel !== 1'b0) begin errors++; $display("FAIL rst_if_adel got=%b want=0", if_adel); end
        reset_n = 1'b1;
        #1;
        checks++; if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL first_cycle_req got=%b want=0", imem.imem_req); end
        @(negedge clk);
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h3000) begin
            errors++; $display("FAIL second_cycle_req got=%b/%h want=1/00003000", imem.imem_req, imem.imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] p, ins; logic ad; bit ok; int last;
        last = 0;
        for (int k = 0; k < 3; k++) begin
            wait_slot(p, ins, ad, ok);
            checks++; if (!ok || p !== 32'h3000 + 32'(4 * k) || ins !== mem_fn(p) || ad !== 1'b0) begin
                errors++; $display("FAIL seq_slot%0d got=%h/%h/%b ok=%0d want=%h", k, p, ins, ad, ok, 32'h3000 + 32'(4 * k));
            end
            if (k > 0) begin
                checks++; if (cyc - last !== 2) begin errors++; $display("FAIL seq_period got=%0d want=2", cyc - last); end
            end
            last = cyc;
        end
    endtask

    task automatic test_branch();
        logic [31:0] p, ins; logic ad; bit ok;
        logic [31:0] want [2];
        for (int t = 0; t < 2; t++) begin
            do_reset();
            wait_slot(p, ins, ad, ok);
            issue_id(2'd1, 32'h3000, t == 0, 16'hFFFF, 26'd0, 32'd0);
            want[0] = 32'h3004;
            want[1] = (t == 0) ? 32'h3000 : 32'h3008;
            for (int k = 0; k < 2; k++) begin
                wait_slot(p, ins, ad, ok);
                checks++; if (!ok || p !== want[k] || ins !== mem_fn(want[k])) begin
                    errors++; $display("FAIL branch_take%0d_slot%0d got=%h ok=%0d want=%h", 1 - t, k, p, ok, want[k]);
                end
            end
        end
    endtask

    task automatic test_jump();
        logic [31:0] p, ins; logic ad; bit ok;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            mem_lat = (t == 0) ? 0 : 3;
            for (int k = 0; k < 5; k++) wait_slot(p, ins, ad, ok);
            checks++; if (!ok || p !== 32'h3010) begin errors++; $display("FAIL jump%0d_pre got=%h want=00003010", t, p); end
            issue_id(2'd2, 32'h3010, 1'b0, 16'd0, 26'h0000C10, 32'd0);
            wait_slot(p, ins, ad, ok);
            checks++; if (!ok || p !== 32'h3014 || ins !== mem_fn(32'h3014)) begin
                errors++; $display("FAIL jump%0d_delay got=%h ok=%0d want=00003014", t, p, ok);
            end
            wait_slot(p, ins, ad, ok);
            checks++; if (!ok || p !== 32'h3040 || ins !== mem_fn(32'h3040)) begin
                errors++; $display("FAIL jump%0d_target got=%h ok=%0d want=00003040", t, p, ok);
            end
        end
        mem_lat = 0;
    endtask

    task automatic test_stall();
        logic [31:0] p, ins, rp, ri; logic ad; bit ok;
        do_reset();
        wait_slot(p, ins, ad, ok);
        stall = 1'b1;
        for (int i = 0; i < 20 && !if_valid; i++) @(negedge clk);
        rp = if_pc; ri = if_instr;
        checks++; if (rp !== 32'h3004) begin errors++; $display("FAIL stall_held_pc got=%h want=00003004", rp); end
        for (int j = 0; j < 4; j++) begin
            // A jump presented during stall must not be captured.
            id_valid = (j < 3); npc_op = 2'd2; id_pc = 32'h3004; instr_index = 26'h0001400;
            @(negedge clk);
            checks++; if (if_valid !== 1'b1 || if_pc !== rp || if_instr !== ri || imem.imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_frozen%0d got=%b/%h/%h req=%b want=1/%h/%h req=0", j, if_valid, if_pc, if_instr, imem.imem_req, rp, ri);
            end
        end
        id_valid = 1'b0;
        stall = 1'b0;
        wait_slot(p, ins, ad, ok);
        wait_slot(p, ins, ad, ok);
        checks++; if (!ok || p !== 32'h3008) begin errors++; $display("FAIL stall_release_next got=%h want=00003008", p); end
    endtask

    task automatic test_jreg_illegal();
        logic [31:0] p, ins; logic ad; bit ok;
        logic [31:0] tgt [2];
        tgt[0] = 32'h3002; tgt[1] = 32'h8000;
        for (int t = 0; t < 2; t++) begin
            do_reset();
            wait_slot(p, ins, ad, ok);
            issue_id(2'd3, 32'h3000, 1'b0, 16'd0, 26'd0, tgt[t]);
            wait_slot(p, ins, ad, ok);
            checks++; if (!ok || p !== 32'h3004 || ad !== 1'b0) begin errors++; $display("FAIL jreg%0d_delay got=%h/%b want=00003004/0", t, p, ad); end
            wait_slot(p, ins, ad, ok);
            checks++; if (!ok || p !== tgt[t] || ad !== 1'b1 || ins !== 32'd0) begin
                errors++; $display("FAIL jreg%0d_adel got=%h/%b/%h ok=%0d want=%h/1/0", t, p, ad, ins, ok, tgt[t]);
            end
        end
    endtask

    task automatic test_reset_midreq();
        logic [31:0] p, ins; logic ad; bit ok;
        do_reset();
        wait_slot(p, ins, ad, ok);
        mem_lat = 10;
        wait_slot(p, ins, ad, ok);
        checks++; if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h3008) begin
            errors++; $display("FAIL midreq_pre got=%b/%h want=1/00003008", imem.imem_req, imem.imem_addr);
        end
        reset_n = 1'b0; force_ack = 1'b1;
        #1;
        checks++; if (imem.imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL midreq_drop got=%b/%b want=0/0", imem.imem_req, if_valid);
        end
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem.imem_req !== 1'b0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL midreq_late_ack got=%b/%b want=0/0", imem.imem_req, if_valid);
        end
        force_ack = 1'b0; mem_lat = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_slot(p, ins, ad, ok);
        checks++; if (!ok || p !== 32'h3000 || ins !== mem_fn(32'h3000)) begin
            errors++; $display("FAIL midreq_restart got=%h/%h ok=%0d want=00003000/%h", p, ins, ok, mem_fn(32'h3000));
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, mtgt, want_i;
        bit mpend, checked, evt, hand;
        int slots, v;
        do_reset();
        mem_rand = 1'b1;
        exp_pc = 32'h3000; mpend = 1'b0; checked = 1'b0; slots = 0; mtgt = 32'd0;
        for (int c = 0; c < 900; c++) begin
            if (if_valid && !checked) begin
                want_i = model_legal(exp_pc) ? mem_fn(exp_pc) : 32'd0;
                checks++; if (if_pc !== exp_pc || if_instr !== want_i || if_adel !== !model_legal(exp_pc)) begin
                    errors++; $display("FAIL rand_slot%0d got=%h/%h/%b want=%h/%h/%b", slots, if_pc, if_instr, if_adel, exp_pc, want_i, !model_legal(exp_pc));
                end
                checked = 1'b1;
                slots++;
            end
            stall = ($urandom_range(0, 3) == 0);
            id_valid = 1'b0;
            if (!mpend && $urandom_range(0, 5) == 0) begin
                id_valid = 1'b1;
                npc_op   = 2'($urandom_range(0, 3));
                id_pc    = 32'h3000 + 32'($urandom_range(0, 4000)) * 32'd4;
                br_take  = 1'($urandom_range(0, 1));
                v        = int'($urandom_range(0, 511)) - 256;
                imm16    = v[15:0];
                instr_index = 26'($urandom_range(32'hC00, 32'h1BFF));
                jr_target = 32'h3000 + 32'($urandom_range(0, 4000)) * 32'd4 +
                            (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
            end
            evt  = id_valid && !stall && (npc_op == 2'd2 || npc_op == 2'd3 || (npc_op == 2'd1 && br_take));
            hand = if_valid && !stall;
            assert (!(evt && mpend)) else $error("FAIL double_redirect at cycle %0d", cyc);
            if (evt) begin
                mpend = 1'b1;
                mtgt  = model_target(npc_op, id_pc, imm16, instr_index, jr_target);
            end
            if (hand) begin
                exp_pc  = mpend ? mtgt : exp_pc + 32'd4;
                mpend   = 1'b0;
                checked = 1'b0;
            end
            @(negedge clk);
        end
        stall = 1'b0; id_valid = 1'b0; mem_rand = 1'b0;
        checks++; if (slots < 60) begin errors++; $display("FAIL rand_progress got=%0d slots want>=60", slots); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_jreg_illegal();
        test_reset_midreq();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
